// File: rtl/regfile_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_arbiter_if
//
// One requester channel of the register-file arbiter: a valid/ready request
// (op, register index, write data) plus a one-cycle-latency response strobe
// with read data.
//
//   valid       requester -> arbiter  request valid
//   write       requester -> arbiter  1 = write, 0 = read
//   addr        requester -> arbiter  register index
//   wdata       requester -> arbiter  write data
//   ready       arbiter -> requester  request accepted this cycle
//   resp_valid  arbiter -> requester  response strobe (one cycle per grant)
//   resp_rdata  arbiter -> requester  read data (0 for writes, held between strobes)
// -----------------------------------------------------------------------------
interface regfile_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 24
);
  logic              valid;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output valid, write, addr, wdata,
    input  ready, resp_valid, resp_rdata
  );

  modport slave (
    input  valid, write, addr, wdata,
    output ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//
// Shares a single-port register file between two requesters (R0 = operand
// read, R1 = writeback/debug) with round-robin arbitration, and provides a
// clear sequencer that sweeps every entry to zero on command.
//
//   clk, rst_n   clock, asynchronous active-low reset
//   req0, req1   requester channels (regfile_arbiter_if.slave)
//   clr_req      start a clear sweep (level, sampled while arbitrating)
//   clr_busy     clear sweep in progress
//   clr_done     one-cycle pulse in the first arbitration cycle after a sweep
//   rf_addr      register file address (requester index zero-extended)
//   rf_wdata     register file write data
//   rf_wr        register file write enable
//   rf_rdata     register file combinational read data
// -----------------------------------------------------------------------------
module regfile_arbiter #(
  parameter int DATA_W    = 24,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = 4,
  parameter int RF_ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_arbiter_if.slave     req0,
  regfile_arbiter_if.slave     req1,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic [RF_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic                 rf_wr,
  input  logic [DATA_W-1:0]    rf_rdata
);

  localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_ARB,
    ST_CLEAR
  } state_e;

  state_e             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;     // 0: R0 wins a tie, 1: R1 wins a tie
  logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               resp0_valid_q, resp0_valid_d;
  logic               resp1_valid_q, resp1_valid_d;
  logic [DATA_W-1:0]  resp0_rdata_q, resp0_rdata_d;
  logic [DATA_W-1:0]  resp1_rdata_q, resp1_rdata_d;
  logic               clr_done_q, clr_done_d;

  logic               grant0, grant1;
  logic               ready0, ready1;

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    clr_cnt_d     = clr_cnt_q;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    resp0_rdata_d = resp0_rdata_q;
    resp1_rdata_d = resp1_rdata_q;
    clr_done_d    = 1'b0;
    grant0        = 1'b0;
    grant1        = 1'b0;
    ready0        = 1'b0;
    ready1        = 1'b0;
    rf_addr       = '0;
    rf_wdata      = '0;
    rf_wr         = 1'b0;

    // Combinational outputs stay quiet while reset is asserted.
    if (rst_n) begin
      unique case (state_q)
        ST_ARB: begin
          if (clr_req) begin
            // Sweep request takes the cycle: nobody is granted.
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
          end else begin
            grant0 = req0.valid && (!req1.valid || !rr_ptr_q);
            grant1 = req1.valid && !grant0;

            if (grant0) begin
              ready0        = 1'b1;
              rf_addr       = RF_ADDR_W'(req0.addr);
              rf_wdata      = req0.wdata;
              rf_wr         = req0.write;
              rr_ptr_d      = 1'b1;
              resp0_valid_d = 1'b1;
              resp0_rdata_d = req0.write ? '0 : rf_rdata;
            end else if (grant1) begin
              ready1        = 1'b1;
              rf_addr       = RF_ADDR_W'(req1.addr);
              rf_wdata      = req1.wdata;
              rf_wr         = req1.write;
              rr_ptr_d      = 1'b0;
              resp1_valid_d = 1'b1;
              resp1_rdata_d = req1.write ? '0 : rf_rdata;
            end
          end
        end

        ST_CLEAR: begin
          // clr_req is deliberately ignored here; the sweep always completes.
          rf_wr    = 1'b1;
          rf_addr  = RF_ADDR_W'(clr_cnt_q);
          rf_wdata = '0;
          if (clr_cnt_q == LAST_IDX) begin
            state_d    = ST_ARB;
            clr_cnt_d  = '0;
            clr_done_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end

        default: state_d = ST_ARB;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ARB;
      rr_ptr_q      <= 1'b0;
      clr_cnt_q     <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
      clr_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      clr_cnt_q     <= clr_cnt_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_rdata_q <= resp0_rdata_d;
      resp1_rdata_q <= resp1_rdata_d;
      clr_done_q    <= clr_done_d;
    end
  end

  assign clr_busy        = (state_q == ST_CLEAR);
  assign clr_done        = clr_done_q;

  assign req0.ready      = ready0;
  assign req0.resp_valid = resp0_valid_q;
  assign req0.resp_rdata = resp0_rdata_q;
  assign req1.ready      = ready1;
  assign req1.resp_valid = resp1_valid_q;
  assign req1.resp_rdata = resp1_rdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
//
// Drives both requester channels and the clear command with directed and
// random stimulus. A behavioural register file answers the DUT's rf_* port;
// an independent transaction-level model (register contents array, sweep
// countdown, tie-break owner) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

  localparam int DATA_W    = 24;
  localparam int NUM_REGS  = 16;
  localparam int ADDR_W    = 4;
  localparam int RF_ADDR_W = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clr_req;
  logic                 clr_busy;
  logic                 clr_done;
  logic [RF_ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0]    rf_wdata;
  logic                 rf_wr;
  logic [DATA_W-1:0]    rf_rdata;

  regfile_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r0_if ();
  regfile_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r1_if ();

  regfile_arbiter #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .RF_ADDR_W(RF_ADDR_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (r0_if.slave),
    .req1    (r1_if.slave),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .rf_addr (rf_addr),
    .rf_wdata(rf_wdata),
    .rf_wr   (rf_wr),
    .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural register file (environment, not the reference model)
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] init_val(input int i);
    return DATA_W'(24'h101010 * i + 24'h005A5A);
  endfunction

  logic [DATA_W-1:0] tb_rf [NUM_REGS];
  bit                tb_rf_loaded = 1'b0;

  always @(posedge clk) begin
    if (!tb_rf_loaded) begin
      for (int i = 0; i < NUM_REGS; i++) tb_rf[i] <= init_val(i);
      tb_rf_loaded <= 1'b1;
    end else if (rf_wr) begin
      tb_rf[rf_addr[ADDR_W-1:0]] <= rf_wdata;
    end
  end

  assign rf_rdata = tb_rf_loaded ? tb_rf[rf_addr[ADDR_W-1:0]] : '0;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks   = 0;
  int n_failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s @%0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: register contents, sweep progress, tie owner, and the
  // responses/done pulse promised for the current cycle.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  bit                m_in_sweep;
  int                m_sweep_left;    // entries still to clear, including this cycle
  int                m_tie_owner;     // requester that wins the next tie
  bit                m_resp_v [2];
  logic [DATA_W-1:0] m_resp_d [2];
  bit                m_done;

  task automatic model_reset();
    m_in_sweep   = 1'b0;
    m_sweep_left = 0;
    m_tie_owner  = 0;
    m_resp_v[0]  = 1'b0;
    m_resp_v[1]  = 1'b0;
    m_resp_d[0]  = '0;
    m_resp_d[1]  = '0;
    m_done       = 1'b0;
  endtask

  // Current-cycle stimulus, recorded by the driver for the model.
  bit                s_v [2];
  bit                s_w [2];
  int                s_a [2];
  logic [DATA_W-1:0] s_d [2];
  bit                s_clr;

  // Called mid-cycle: compare every output, then advance the model one cycle.
  task automatic model_cycle();
    bit                e_rdy [2];
    bit                e_wr;
    int                e_addr;
    logic [DATA_W-1:0] e_wd;
    bit                n_v [2];
    bit                n_done;
    int                win;

    e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
    e_wr = 1'b0; e_addr = 0; e_wd = '0;
    n_v[0] = 1'b0; n_v[1] = 1'b0; n_done = 1'b0;

    check("resp0_valid", 32'(r0_if.resp_valid), 32'(m_resp_v[0]));
    check("resp0_rdata", 32'(r0_if.resp_rdata), 32'(m_resp_d[0]));
    check("resp1_valid", 32'(r1_if.resp_valid), 32'(m_resp_v[1]));
    check("resp1_rdata", 32'(r1_if.resp_rdata), 32'(m_resp_d[1]));
    check("clr_done",    32'(clr_done),         32'(m_done));
    check("clr_busy",    32'(clr_busy),         32'(m_in_sweep));

    if (m_in_sweep) begin
      int idx = NUM_REGS - m_sweep_left;
      e_wr   = 1'b1;
      e_addr = idx;
      m_regs[idx] = '0;
      m_sweep_left--;
      if (m_sweep_left == 0) begin
        m_in_sweep = 1'b0;
        n_done     = 1'b1;
      end
    end else if (s_clr) begin
      m_in_sweep   = 1'b1;
      m_sweep_left = NUM_REGS;
    end else begin
      if (s_v[0] && s_v[1]) win = m_tie_owner;
      else if (s_v[0])      win = 0;
      else if (s_v[1])      win = 1;
      else                  win = -1;
      if (win >= 0) begin
        e_rdy[win]  = 1'b1;
        e_wr        = s_w[win];
        e_addr      = s_a[win];
        e_wd        = s_d[win];
        n_v[win]    = 1'b1;
        m_resp_d[win] = s_w[win] ? '0 : m_regs[s_a[win]];
        if (s_w[win]) m_regs[s_a[win]] = s_d[win];
        m_tie_owner = 1 - win;
      end
    end

    check("req0_ready", 32'(r0_if.ready), 32'(e_rdy[0]));
    check("req1_ready", 32'(r1_if.ready), 32'(e_rdy[1]));
    check("rf_wr",      32'(rf_wr),       32'(e_wr));
    check("rf_addr",    32'(rf_addr),     32'(e_addr));
    check("rf_wdata",   32'(rf_wdata),    32'(e_wd));

    m_resp_v[0] = n_v[0];
    m_resp_v[1] = n_v[1];
    m_done      = n_done;
  endtask

  // One clock cycle: drive inputs just after the rising edge, check at the
  // falling edge, return just after the next rising edge.
  task automatic cycle(input bit v0, input bit w0, input int a0, input logic [DATA_W-1:0] d0,
                       input bit v1, input bit w1, input int a1, input logic [DATA_W-1:0] d1,
                       input bit clr);
    s_v[0] = v0; s_w[0] = w0; s_a[0] = a0 % NUM_REGS; s_d[0] = d0;
    s_v[1] = v1; s_w[1] = w1; s_a[1] = a1 % NUM_REGS; s_d[1] = d1;
    s_clr  = clr;
    r0_if.valid = v0; r0_if.write = w0; r0_if.addr = ADDR_W'(s_a[0]); r0_if.wdata = d0;
    r1_if.valid = v1; r1_if.write = w1; r1_if.addr = ADDR_W'(s_a[1]); r1_if.wdata = d1;
    clr_req = clr;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, 0, 0, '0, 0);
  endtask

  // Reset asserted asynchronously just after an edge: everything must drop at once.
  task automatic reset_abort();
    #1 rst_n = 1'b0;
    #1;
    check("abort_clr_busy",    32'(clr_busy),         32'd0);
    check("abort_rf_wr",       32'(rf_wr),            32'd0);
    check("abort_resp0_valid", 32'(r0_if.resp_valid), 32'd0);
    check("abort_resp1_valid", 32'(r1_if.resp_valid), 32'd0);
    check("abort_clr_done",    32'(clr_done),         32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = init_val(i);
    model_reset();

    // Reset with both requesters valid: combinational outputs must stay 0.
    rst_n   = 1'b0;
    clr_req = 1'b1;
    r0_if.valid = 1'b1; r0_if.write = 1'b1; r0_if.addr = 4'h5; r0_if.wdata = 24'h123456;
    r1_if.valid = 1'b1; r1_if.write = 1'b1; r1_if.addr = 4'h6; r1_if.wdata = 24'h654321;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_ready0",   32'(r0_if.ready),      32'd0);
      check("rst_ready1",   32'(r1_if.ready),      32'd0);
      check("rst_rf_wr",    32'(rf_wr),            32'd0);
      check("rst_rf_addr",  32'(rf_addr),          32'd0);
      check("rst_rf_wdata", 32'(rf_wdata),         32'd0);
      check("rst_resp0",    32'(r0_if.resp_valid), 32'd0);
      check("rst_resp1",    32'(r1_if.resp_valid), 32'd0);
      check("rst_clr_busy", 32'(clr_busy),         32'd0);
      check("rst_clr_done", 32'(clr_done),         32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // First tie goes to R0.
    cycle(1, 0, 1, '0, 1, 0, 2, '0, 0);
    idle(1);

    // R0 write then read of addr 3 (read-after-write).
    cycle(1, 1, 3, 24'hAAAAAA, 0, 0, 0, '0, 0);
    cycle(1, 0, 3, 24'h000000, 0, 0, 0, '0, 0);
    idle(1);
    check("raw_resp0_rdata", 32'(r0_if.resp_rdata), 32'h00AAAAAA);

    // Both valid for 4 cycles: alternating grants.
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, '0, 1, 0, 2, '0, 0);
    idle(1);

    // Clear pulsed while R1 waits; R1 held valid through the sweep.
    cycle(0, 0, 0, '0, 1, 0, 3, '0, 1);
    for (int i = 0; i < NUM_REGS + 1; i++) cycle(0, 0, 0, '0, 1, 0, 3, '0, 0);
    cycle(1, 0, 3, '0, 0, 0, 0, '0, 0);
    idle(1);
    check("post_clear_rdata", 32'(r0_if.resp_rdata), 32'd0);

    // R1 writes addr 15 then addr 0 back-to-back.
    cycle(0, 0, 0, '0, 1, 1, 15, 24'h0F0F0F, 0);
    cycle(0, 0, 0, '0, 1, 1, 0,  24'h0A0A0A, 0);
    idle(2);

    // Reset mid-response: a read response is pending when reset hits.
    cycle(1, 0, 15, '0, 0, 0, 0, '0, 0);
    reset_abort();
    idle(2);

    // Reset mid-sweep at clr_cnt = 7, then a tie goes to R0 with no done pulse.
    cycle(0, 0, 0, '0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, '0, 0, 0, 0, '0, 0);
    reset_abort();
    cycle(1, 0, 8, '0, 1, 0, 5, '0, 0);
    idle(2);

    // clr_req held through a sweep: ignored inside, restarts on the done cycle.
    for (int i = 0; i < NUM_REGS + 2; i++) cycle(1, 0, 4, '0, 1, 0, 9, '0, 1);
    for (int i = 0; i < NUM_REGS + 1; i++) cycle(1, 0, 4, '0, 1, 0, 9, '0, 0);
    idle(1);

    // Randomized traffic with occasional clear requests.
    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            DATA_W'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            DATA_W'($urandom),
            ($urandom_range(0, 39) == 0));
    end
    idle(NUM_REGS + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
